hazard_forward_unit: RTL

Parametrised successor to the pipeline's operand forwarding logic, with load-use hazard detection added. It holds its own shift register of destination tags for in-flight instructions (DEPTH stages after issue). It forwards the youngest valid result to each of NUM_SRC source operands at issue. When a source depends on a load whose data is not yet available, it stalls issue and inserts a bubble. Sits between register-file read and the EX stage.

---
 rtl/hazard_forward_unit_if.sv | 33 +++
 rtl/hazard_forward_unit.sv | 88 ++++++++
 2 files changed

// File: rtl/hazard_forward_unit_if.sv
// Issue/forwarding bus between decode and hazard_forward_unit.
// The master drives issue and operand requests; the slave returns operands, stall and stall_count.
interface hazard_forward_unit_if #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int CNT_W   = 16
);
  logic                        issue_valid;
  logic [REG_AW-1:0]           issue_rd;
  logic                        issue_we;
  logic                        issue_is_load;
  logic                        flush;
  logic [NUM_SRC*REG_AW-1:0]   src_addr;
  logic [NUM_SRC*DATA_W-1:0]   rf_data;
  logic [DEPTH*DATA_W-1:0]     stage_data;
  logic [NUM_SRC*DATA_W-1:0]   fwd_data;
  logic                        stall;
  logic [CNT_W-1:0]            stall_count;

  modport master (
    output issue_valid, issue_rd, issue_we, issue_is_load, flush,
           src_addr, rf_data, stage_data,
    input  fwd_data, stall, stall_count
  );

  modport slave (
    input  issue_valid, issue_rd, issue_we, issue_is_load, flush,
           src_addr, rf_data, stage_data,
    output fwd_data, stall, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Operand forwarding with load-use stall, tracking DEPTH in-flight destination tags.
// Optional `define ZERO_REG_EN hardwires register 0 to zero.
module hazard_forward_unit #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 16
) (
  input logic                  clk,
  input logic                  reset,
  hazard_forward_unit_if.slave bus
);
  localparam int unsigned D  = DEPTH;
  localparam int unsigned NS = NUM_SRC;
  localparam int unsigned DW = DATA_W;
  localparam int unsigned AW = REG_AW;
  localparam int unsigned LR = LOAD_READY;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              is_load;
  } tag_t;

  // tags[0] is stage 1 (EX)
  tag_t                      tags [D];
  logic [NUM_SRC-1:0]        hazard;
  logic [NUM_SRC*DATA_W-1:0] fwd;
  logic                      stall_int;
  logic [CNT_W-1:0]          cnt;
  logic [REG_AW-1:0]         src;
  logic                      haz;
  logic [DATA_W-1:0]         sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < D; k++) tags[k] <= '0;
      cnt <= '0;
    end else begin
      if (bus.flush) begin
        for (int unsigned k = 0; k < D; k++) tags[k] <= '0;
      end else begin
        for (int unsigned k = 1; k < D; k++) tags[k] <= tags[k-1];
        tags[0] <= (bus.issue_valid && !stall_int)
                   ? {1'b1, bus.issue_rd, bus.issue_we, bus.issue_is_load}
                   : '0;
      end
      if (stall_int && (cnt != '1)) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    hazard = '0;
    fwd    = '0;
    src    = '0;
    haz    = 1'b0;
    sel    = '0;
    for (int unsigned i = 0; i < NS; i++) begin
      src = bus.src_addr[i*AW +: AW];
      haz = 1'b0;
      sel = bus.rf_data[i*DW +: DW];
      // Scan oldest to youngest so the youngest match is the one left standing.
      for (int unsigned j = 0; j < D; j++) begin
        if (tags[D-1-j].valid && tags[D-1-j].we && (tags[D-1-j].rd == src)) begin
          haz = tags[D-1-j].is_load && ((D - j) < LR);
          sel = bus.stage_data[(D-1-j)*DW +: DW];
        end
      end
`ifdef ZERO_REG_EN
      if (src == '0) begin
        haz = 1'b0;
        sel = '0;
      end
`endif
      hazard[i]         = haz;
      fwd[i*DW +: DW]   = haz ? bus.rf_data[i*DW +: DW] : sel;
    end
  end

  assign stall_int       = !reset && bus.issue_valid && !bus.flush && (|hazard);
  assign bus.stall       = stall_int;
  assign bus.fwd_data    = fwd;
  assign bus.stall_count = cnt;

endmodule
